rasp_link_rx: RTL
=================

Name: rasp_link_rx

Overview:
- Receives the Raspberry Pi vision/status link: a UART 8N1 serial stream of 3-byte frames.
- Decodes each frame into the level flags rasp_on, obj_inSight and obj_isClose, which drive the robot's top-level motion/claw controller.
- Checks every frame with a checksum and supervises the link with a watchdog, so stale vision data can never keep the robot moving.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- TIMEOUT_CYCLES, 5000000, clk cycles without a valid frame before all flags are cleared (100 ms at 50 MHz).
- SYNC_BYTE, 8'hA5, frame start marker.
- CSUM_KEY, 8'h5A, checksum key; checksum = status ^ CSUM_KEY.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx  in  1  UART line from the Pi, asynchronous, idle high
- rasp_on  out  1  Pi reports ready (status bit 2)
- obj_inSight  out  1  object in camera view (status bit 0)
- obj_isClose  out  1  object within claw reach (status bit 1)
- link_ok  out  1  valid frame received within the last TIMEOUT_CYCLES
- frame_err  out  1  one-cycle pulse on a rejected frame or a UART framing error
- err_cnt  out  8  count of frame_err pulses, saturates at 255

Behaviour:
Reset:
- rst takes effect on the clk edge, including mid-byte and mid-frame.
- All outputs go to 0 and err_cnt to 0.
- The UART FSM goes to IDLE, the parser to P_SYNC, and the watchdog counter to 0.

Input synchronisation:
- rx passes through a 2-FF synchroniser (reset value 1) before any use.

UART FSM (IDLE, START, DATA, STOP):
- IDLE: a synchronised 1->0 transition enters START and clears the bit counter.
- START: after CLKS_PER_BIT/2 cycles, sample rx. If 0, go to DATA. If 1, treat as a glitch: return to IDLE with no error.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx=1: emit an internal byte strobe for 1 cycle with the byte.
  - rx=0: framing error. Pulse frame_err, reset the parser to P_SYNC, and emit no byte strobe.
  - Either way, return to IDLE. A new start edge is accepted from the next cycle.

Parser (P_SYNC, P_STAT, P_CSUM), advancing only on the byte strobe:
- P_SYNC: byte == SYNC_BYTE -> P_STAT; any other byte is ignored with no error.
- P_STAT: latch the byte as status -> P_CSUM. A byte equal to SYNC_BYTE here is still taken as status.
- P_CSUM: commit if byte == status ^ CSUM_KEY and status[7:3] == 0; otherwise pulse frame_err. Either way -> P_SYNC.

Commit:
- Outputs update on the clk edge after the byte strobe (1 cycle latency).
- rasp_on <= status[2].
- obj_inSight <= status[2] & status[0].
- obj_isClose <= status[2] & status[1].
- link_ok <= 1; watchdog counter <= 0.
- If status[2] = 0, the sight and close flags are forced to 0 regardless of bits 0 and 1.

Watchdog:
- The counter increments every cycle and saturates at TIMEOUT_CYCLES.
- When it reaches TIMEOUT_CYCLES, rasp_on, obj_inSight, obj_isClose and link_ok are all cleared on that edge.
- If a commit and the timeout occur on the same cycle, the commit wins.

Error counting:
- err_cnt increments on every frame_err pulse and holds at 255.
- frame_err is never asserted on two consecutive cycles.

Other rules:
- Flags are level outputs that hold between frames. There is no glitch or partial update, because all three flags change on the same edge.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000):
- Valid frame: send A5 05 5F -> 1 cycle after the checksum stop-bit sample: rasp_on=1, obj_inSight=1, obj_isClose=0, link_ok=1, frame_err never asserted.
- Ready gating: send A5 03 59 (Pi not ready) -> all three flags 0 and link_ok=1. Then send A5 07 5D -> all three flags 1.
- Bad checksum: send A5 05 00 -> frame_err high for exactly 1 cycle, err_cnt=1, flags unchanged from the previous frame.
- Framing/glitch: send a byte with stop bit 0 mid-frame -> frame_err pulse and parser in P_SYNC. A 4-cycle low glitch on rx -> no byte, no error. A following A5 04 5E is then accepted (rasp_on=1 only).
- Watchdog: after a valid A5 07 5D, send nothing -> flags and link_ok drop exactly 2000 cycles after the commit. A frame at cycle 1999 keeps them high.
- Reset mid-byte: assert rst during the DATA bits of A5 -> outputs 0, err_cnt=0. A complete A5 05 5F after reset decodes correctly. 300 bad frames give err_cnt=255.

Source files
------------

// File: rtl/rasp_link_rx.sv
// rasp_link_rx: UART 8N1 receiver and checksummed frame parser for the Pi vision/status link, with a link watchdog
module rasp_link_rx #(
  parameter int          CLKS_PER_BIT   = 434,
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  CSUM_KEY       = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rasp_on,
  output logic       obj_inSight,
  output logic       obj_isClose,
  output logic       link_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0] TO      = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] TO_M1   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  localparam logic [1:0] P_SYNC = 2'd0, P_STAT = 2'd1, P_CSUM = 2'd2;
  logic          r_rx_meta, r_rx_sync, r_rx_d;
  logic [1:0]    r_ustate, r_pstate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift, r_byte, r_status;
  logic          r_stb;
  logic          r_rasp_on, r_in_sight, r_is_close, r_link_ok, r_frame_err;
  logic [7:0]    r_err_cnt;
  logic [WW-1:0] r_wd;
  logic w_tick_half, w_tick, w_ferr, w_stb_next, w_csum_ok, w_commit, w_cerr, w_err;
  always_comb begin
    w_tick_half = r_cnt == HALF_M1;
    w_tick      = r_cnt == FULL_M1;
    w_ferr      = r_ustate == S_STOP && w_tick && !r_rx_sync;
    w_stb_next  = r_ustate == S_STOP && w_tick && r_rx_sync;
    w_csum_ok   = r_byte == (r_status ^ CSUM_KEY) && r_status[7:3] == 5'd0;
    w_commit    = r_stb && r_pstate == P_CSUM && w_csum_ok;
    w_cerr      = r_stb && r_pstate == P_CSUM && !w_csum_ok;
    w_err       = w_ferr || w_cerr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_d    <= 1'b1;
      r_ustate  <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_stb     <= 1'b0;
      r_byte    <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_d    <= r_rx_sync;
      r_stb     <= w_stb_next;
      if (w_stb_next) r_byte <= r_shift;
      case (r_ustate)
        S_IDLE: if (r_rx_d && !r_rx_sync) begin
          r_ustate <= S_START;
          r_cnt    <= '0;
          r_bit    <= '0;
        end
        S_START: if (w_tick_half) begin
          r_ustate <= r_rx_sync ? S_IDLE : S_DATA;
          r_cnt    <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        S_DATA: if (w_tick) begin
          r_cnt   <= '0;
          r_shift <= {r_rx_sync, r_shift[7:1]};
          r_bit   <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_ustate <= S_STOP;
        end else r_cnt <= r_cnt + 1'b1;
        default: if (w_tick) begin
          r_ustate <= S_IDLE;
          r_cnt    <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate    <= P_SYNC;
      r_status    <= '0;
      r_rasp_on   <= 1'b0;
      r_in_sight  <= 1'b0;
      r_is_close  <= 1'b0;
      r_link_ok   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
      r_wd        <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_ferr) r_pstate <= P_SYNC;
      else if (r_stb) r_pstate <= r_pstate == P_SYNC ? (r_byte == SYNC_BYTE ? P_STAT : P_SYNC) :
                                  r_pstate == P_STAT ? P_CSUM : P_SYNC;
      if (r_stb && r_pstate == P_STAT) r_status <= r_byte;
      // a commit on the timeout cycle takes priority over clearing
      if (w_commit) begin
        r_rasp_on  <= r_status[2];
        r_in_sight <= r_status[2] & r_status[0];
        r_is_close <= r_status[2] & r_status[1];
        r_link_ok  <= 1'b1;
        r_wd       <= '0;
      end else begin
        r_wd <= r_wd == TO ? r_wd : r_wd + 1'b1;
        if (r_wd == TO_M1) begin
          r_rasp_on  <= 1'b0;
          r_in_sight <= 1'b0;
          r_is_close <= 1'b0;
          r_link_ok  <= 1'b0;
        end
      end
    end
  end
  assign rasp_on     = r_rasp_on;
  assign obj_inSight = r_in_sight;
  assign obj_isClose = r_is_close;
  assign link_ok     = r_link_ok;
  assign frame_err   = r_frame_err;
  assign err_cnt     = r_err_cnt;
endmodule
